// File: rtl/rdi_stall_hs_ctrl.sv
// RDI stall handshake controller: drives per-channel stall requests, collects
// acks, gates trdy while the stall is held, with timeout/abort/error handling.
module rdi_stall_hs_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic              lclk,
  input  logic              sys_rst,
  input  logic              i_stall_start,
  input  logic              i_stall_release,
  input  logic              i_abort,
  input  logic              i_err_clr,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic [NUM_CH-1:0] i_lp_stallack,
  input  logic [NUM_CH-1:0] i_trdy_src,
  output logic [NUM_CH-1:0] o_pl_stallreq,
  output logic [NUM_CH-1:0] o_pl_trdy,
  output logic              o_stall_held,
  output logic              o_stall_done,
  output logic              o_stall_timeout,
  output logic              o_busy,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HOLD = 3'd2,
    S_REL  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam bit              TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] blk, blk_nxt;
  logic [NUM_CH-1:0] stallreq_nxt;
  logic              all_ack, none_ack, start_ok, expired, abort_act;

  always_comb begin
    all_ack   = &(i_lp_stallack | ~en_q);
    none_ack  = ~|(i_lp_stallack & en_q);
    start_ok  = i_stall_start && (|i_ch_en) && !(|(i_lp_stallack & i_ch_en));
    expired   = TO_EN && (cnt == CNT_LAST);
    abort_act = i_abort && (state inside {S_REQ, S_HOLD, S_REL});
  end

  always_ff @(posedge lclk) begin
    if (!sys_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      en_q          <= '0;
      blk           <= '0;
      o_pl_stallreq <= '0;
      o_stall_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      blk           <= blk_nxt;
      o_pl_stallreq <= stallreq_nxt;
      o_stall_done  <= (state == S_DONE);
      if (state == S_IDLE && start_ok)
        en_q <= i_ch_en;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (abort_act) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state_nxt = S_REQ;
            cnt_nxt   = '0;
          end
        end
        S_REQ: begin
          if (all_ack)
            state_nxt = S_HOLD;
          else if (expired)
            state_nxt = S_ERR;
          else if (TO_EN)
            cnt_nxt = cnt + 1'b1;
        end
        S_HOLD: begin
          if (i_stall_release) begin
            state_nxt = S_REL;
            cnt_nxt   = '0;
          end
        end
        S_REL: begin
          if (none_ack)
            state_nxt = S_DONE;
          else if (expired)
            state_nxt = S_ERR;
          else if (TO_EN)
            cnt_nxt = cnt + 1'b1;
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   if (i_err_clr) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // blk survives DONE and clears from IDLE, so trdy returns the cycle after the done pulse
  always_comb begin
    blk_nxt = blk;
    case (state)
      S_IDLE:  blk_nxt = '0;
      S_REQ:   blk_nxt = blk | (i_lp_stallack & en_q);
      S_HOLD:  blk_nxt = en_q;
      default: ;
    endcase
    if (abort_act || state_nxt == S_ERR)
      blk_nxt = '0;
    stallreq_nxt = ((state == S_REQ || state == S_HOLD) &&
                    (state_nxt == S_REQ || state_nxt == S_HOLD)) ? en_q : '0;
  end

  always_comb begin
    o_pl_trdy       = i_trdy_src & ~blk;
    o_stall_held    = (state == S_HOLD);
    o_stall_timeout = (state == S_ERR);
    o_busy          = (state != S_IDLE);
    o_state         = state;
  end

`ifndef SYNTHESIS
  a_no_req_disabled: assert property (@(posedge lclk) disable iff (!sys_rst)
    (o_pl_stallreq & ~en_q) == '0);
  a_done_to_excl: assert property (@(posedge lclk) disable iff (!sys_rst)
    !(o_stall_done && o_stall_timeout));
  a_done_pulse: assert property (@(posedge lclk) disable iff (!sys_rst)
    o_stall_done |=> !o_stall_done);
`endif

endmodule

// File: tb/tb_rdi_stall_hs_ctrl.sv
// Bench for rdi_stall_hs_ctrl: directed handshake scenarios plus randomized
// traffic, all checked against a behavioural model of the stall sequence.
module tb_rdi_stall_hs_ctrl;

  localparam int TOUT = 8;

  logic       lclk;
  logic       sys_rst;
  logic       i_stall_start, i_stall_release, i_abort, i_err_clr;
  logic [1:0] i_ch_en, i_lp_stallack, i_trdy_src;
  logic [1:0] o_pl_stallreq, o_pl_trdy;
  logic       o_stall_held, o_stall_done, o_stall_timeout, o_busy;
  logic [2:0] o_state;

  int total = 0;
  int bad   = 0;

  // Model: phase number uses the published encoding (0 idle .. 5 error)
  int         m_st  = 0;
  int         m_cnt = 0;
  logic [1:0] m_en  = '0;
  logic [1:0] m_blk = '0;
  logic [1:0] m_req = '0;
  logic       m_done = 1'b0;

  rdi_stall_hs_ctrl #(
    .NUM_CH      (2),
    .TIMEOUT_CYC (TOUT),
    .CNT_W       (4)
  ) dut (
    .lclk            (lclk),
    .sys_rst         (sys_rst),
    .i_stall_start   (i_stall_start),
    .i_stall_release (i_stall_release),
    .i_abort         (i_abort),
    .i_err_clr       (i_err_clr),
    .i_ch_en         (i_ch_en),
    .i_lp_stallack   (i_lp_stallack),
    .i_trdy_src      (i_trdy_src),
    .o_pl_stallreq   (o_pl_stallreq),
    .o_pl_trdy       (o_pl_trdy),
    .o_stall_held    (o_stall_held),
    .o_stall_done    (o_stall_done),
    .o_stall_timeout (o_stall_timeout),
    .o_busy          (o_busy),
    .o_state         (o_state)
  );

  initial begin
    lclk = 1'b0;
    forever #5 lclk = ~lclk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int         nst;
    logic [1:0] nblk;
    bit         all_ack, none_ack, ab;
    if (!sys_rst) begin
      m_st = 0; m_cnt = 0; m_en = '0; m_blk = '0; m_req = '0; m_done = 1'b0;
      return;
    end
    all_ack  = ((i_lp_stallack | ~m_en) == 2'b11);
    none_ack = ((i_lp_stallack & m_en) == 2'b00);
    ab       = i_abort && (m_st >= 1 && m_st <= 3);
    nst      = m_st;
    nblk     = m_blk;
    m_done   = (m_st == 4);
    if (ab) begin
      nst  = 0;
      nblk = '0;
    end else begin
      case (m_st)
        0: begin
          nblk = '0;
          if (i_stall_start && i_ch_en != 2'b00 && (i_lp_stallack & i_ch_en) == 2'b00) begin
            nst = 1; m_en = i_ch_en; m_cnt = 0;
          end
        end
        1: begin
          nblk = m_blk | (i_lp_stallack & m_en);
          if (all_ack) nst = 2;
          else if (m_cnt == TOUT - 1) begin nst = 5; nblk = '0; end
          else m_cnt++;
        end
        2: begin
          nblk = m_en;
          if (i_stall_release) begin nst = 3; m_cnt = 0; end
        end
        3: begin
          if (none_ack) nst = 4;
          else if (m_cnt == TOUT - 1) begin nst = 5; nblk = '0; end
          else m_cnt++;
        end
        4: nst = 0;
        default: if (i_err_clr) nst = 0;
      endcase
    end
    m_req = ((m_st == 1 || m_st == 2) && (nst == 1 || nst == 2)) ? m_en : 2'b00;
    m_st  = nst;
    m_blk = nblk;
  endtask

  task automatic compare_all();
    chk("state",   8'(o_state),         8'(m_st));
    chk("stallreq", 8'(o_pl_stallreq),  8'(m_req));
    chk("trdy",    8'(o_pl_trdy),       8'(i_trdy_src & ~m_blk));
    chk("held",    8'(o_stall_held),    8'(m_st == 2));
    chk("done",    8'(o_stall_done),    8'(m_done));
    chk("timeout", 8'(o_stall_timeout), 8'(m_st == 5));
    chk("busy",    8'(o_busy),          8'(m_st != 0));
  endtask

  task automatic tick();
    @(posedge lclk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int         dcnt;
    logic [1:0] exp_trdy;
    sys_rst = 1'b0; i_stall_start = 1'b0; i_stall_release = 1'b0;
    i_abort = 1'b0; i_err_clr = 1'b0; i_ch_en = 2'b11;
    i_lp_stallack = 2'b00; i_trdy_src = 2'b11;
    repeat (3) tick();
    chk("rst_state", 8'(o_state), 8'd0);
    chk("rst_req",   8'(o_pl_stallreq), 8'd0);
    chk("rst_trdy",  8'(o_pl_trdy), 8'h3);
    sys_rst = 1'b1;

    // S1: full sequence with test-plan timing
    i_stall_start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_trdy[0] = !(k >= 4 && k <= 14);
      exp_trdy[1] = !(k >= 6 && k <= 14);
      chk("s1_req",  8'(o_pl_stallreq), (k >= 2 && k <= 10) ? 8'h3 : 8'h0);
      chk("s1_trdy", 8'(o_pl_trdy), 8'(exp_trdy));
      chk("s1_held", 8'(o_stall_held), 8'(k >= 6 && k <= 10));
      chk("s1_done", 8'(o_stall_done), 8'(k == 14));
      i_stall_start    = 1'b0;
      i_lp_stallack[0] = (k >= 3 && k < 12);
      i_lp_stallack[1] = (k >= 5 && k < 12);
      i_stall_release  = (k == 10);
    end

    // S2: only ch0 enabled; ch1 noise must be ignored
    i_ch_en = 2'b01; i_stall_start = 1'b1; dcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("s2_req1",  8'(o_pl_stallreq[1]), 8'd0);
      chk("s2_trdy1", 8'(o_pl_trdy[1]), 8'(i_trdy_src[1]));
      if (o_stall_done) dcnt++;
      i_stall_start    = 1'b0;
      i_trdy_src       = 2'($urandom);
      i_lp_stallack[1] = 1'($urandom);
      i_lp_stallack[0] = (k >= 3 && k < 10);
      i_stall_release  = (k == 6);
      if (k == 4) i_ch_en = 2'b11;
    end
    chk("s2_done_cnt", 8'(dcnt), 8'd1);
    i_lp_stallack = 2'b00; i_trdy_src = 2'b11; i_ch_en = 2'b11;
    tick();

    // S3: ch1 never acks -> timeout, abort ignored in ERR, cleared by err_clr
    i_stall_start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("s3_state", 8'(o_state), (k <= 8) ? 8'd1 : 8'd5);
      chk("s3_to",    8'(o_stall_timeout), 8'(k >= 9));
      if (k >= 9) chk("s3_req", 8'(o_pl_stallreq), 8'd0);
      i_stall_start    = 1'b0;
      i_lp_stallack[0] = (k >= 2);
      i_abort          = (k == 10);
    end
    i_lp_stallack = 2'b00; i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("s3_clr_state", 8'(o_state), 8'd0);

    // S4: last ack lands on the expiry cycle -> success
    i_stall_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("s4_state", 8'(o_state), (k <= 8) ? 8'd1 : 8'd2);
      chk("s4_to",    8'(o_stall_timeout), 8'd0);
      i_stall_start    = 1'b0;
      i_lp_stallack[0] = (k >= 2);
      i_lp_stallack[1] = (k >= 8);
    end
    i_stall_release = 1'b1;
    tick();
    i_stall_release = 1'b0; i_lp_stallack = 2'b00;
    tick();
    tick();
    chk("s4_done", 8'(o_stall_done), 8'd1);
    tick();

    // S5: abort together with release in HOLD
    i_stall_start = 1'b1;
    tick();
    i_stall_start = 1'b0; i_lp_stallack = 2'b11;
    tick();
    chk("s5_hold", 8'(o_state), 8'd2);
    i_abort = 1'b1; i_stall_release = 1'b1;
    tick();
    i_abort = 1'b0; i_stall_release = 1'b0;
    chk("s5_state", 8'(o_state), 8'd0);
    chk("s5_req",   8'(o_pl_stallreq), 8'd0);
    chk("s5_trdy",  8'(o_pl_trdy), 8'(i_trdy_src));
    chk("s5_done",  8'(o_stall_done), 8'd0);
    i_lp_stallack = 2'b00;
    tick();
    chk("s5_done2", 8'(o_stall_done), 8'd0);

    // S6: stale ack holds IDLE; then reset mid-HOLD
    i_lp_stallack = 2'b01; i_stall_start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("s6_idle", 8'(o_state), 8'd0);
      chk("s6_req",  8'(o_pl_stallreq), 8'd0);
    end
    i_lp_stallack = 2'b00;
    tick();
    chk("s6_start", 8'(o_state), 8'd1);
    tick();
    chk("s6_req_up", 8'(o_pl_stallreq), 8'h3);
    i_lp_stallack = 2'b11;
    tick();
    chk("s6_held", 8'(o_stall_held), 8'd1);
    sys_rst = 1'b0;
    tick();
    chk("s6_rst_state", 8'(o_state), 8'd0);
    chk("s6_rst_req",   8'(o_pl_stallreq), 8'd0);
    chk("s6_rst_held",  8'(o_stall_held), 8'd0);
    chk("s6_rst_busy",  8'(o_busy), 8'd0);
    chk("s6_rst_trdy",  8'(o_pl_trdy), 8'(i_trdy_src));
    sys_rst = 1'b1; i_stall_start = 1'b0; i_lp_stallack = 2'b00;
    tick();

    // Randomized traffic; acks loosely follow the requests to reach every phase
    for (int n = 0; n < 3000; n++) begin
      tick();
      sys_rst         = ($urandom_range(0, 199) != 0);
      i_stall_start   = ($urandom_range(0, 3) != 0);
      i_stall_release = ($urandom_range(0, 3) == 0);
      i_abort         = ($urandom_range(0, 31) == 0);
      i_err_clr       = ($urandom_range(0, 3) == 0);
      i_ch_en         = 2'($urandom);
      i_trdy_src      = 2'($urandom);
      for (int c = 0; c < 2; c++)
        i_lp_stallack[c] = ($urandom_range(0, 3) != 0) ? o_pl_stallreq[c] : 1'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
